// File: rtl/wb_sub_tx_fifo.sv
// Wishbone classic slave on the "sub" submap port: writes push words into a
// first-word-fall-through FIFO drained by a valid/ready stream; reads return status.
module wb_sub_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic        wb_stall_o,
   output logic [31:0] wb_dat_o,
   output logic [31:0] out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;

   logic        acc, wr_acc, rd_acc, full, empty, pop, push;
   logic [31:0] wdata, status;

   always_comb begin
      acc    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
      wr_acc = acc & wb_we_i;
      rd_acc = acc & ~wb_we_i;
      full   = (level == LVL_FULL);
      empty  = (level == '0);
      pop    = ~empty & out_ready_i;
      // a pop at the same edge frees the slot, so a full FIFO can still accept
      push   = wr_acc & (~full | pop);
      wdata  = '0;
      for (int b = 0; b < 4; b++)
         wdata[8*b +: 8] = wb_sel_i[b] ? wb_dat_i[8*b +: 8] : 8'h00;
      status = {overflow, full, empty, 13'd0, 16'(level)};
   end

   assign out_valid_o = ~empty;
   assign out_data_o  = empty ? '0 : mem[rd_ptr];
   assign wb_stall_o  = ~wb_ack_o & wb_cyc_i & wb_stb_i;
   assign wb_err_o    = 1'b0;
   assign wb_rty_o    = 1'b0;

   always_ff @(posedge clk_i)
      if (push) mem[wr_ptr] <= wdata;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         wb_ack_o <= acc;
         if (rd_acc) begin
            wb_dat_o <= status;
            overflow <= 1'b0;
         end else if (wr_acc && !push) begin
            overflow <= 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({push, pop})
            2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
            2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sub_tx_fifo.sv
// Bench for wb_sub_tx_fifo: per-cycle stimulus feeds a queue-based FIFO model;
// a monitor compares ack, stall, stream head and read status against the model.
module tb_wb_sub_tx_fifo;

   localparam int DEPTH = 16;

   logic        clk_i = 1'b0, rst_n_i = 1'b0;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [3:0]  wb_sel_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o;
   logic [31:0] wb_dat_o, out_data_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;

   wb_sub_tx_fifo #(.DEPTH_LOG2(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_sel_i(wb_sel_i),
      .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
      .wb_stall_o(wb_stall_o), .wb_dat_o(wb_dat_o),
      .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int  vectors = 0, errs = 0;
   int  lvl = 0, vis_lvl = 0;
   bit  ovf = 0, m_ack = 0, m_rd = 0, vis_ack = 0, vis_rd = 0;
   logic [31:0] exp_stream[$];
   logic [31:0] exp_status[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] se);
      logic [31:0] m = '0;
      for (int b = 0; b < 4; b++) if (se[b]) m[8*b +: 8] = d[8*b +: 8];
      return m;
   endfunction

   task automatic model_reset();
      lvl = 0; ovf = 0; m_ack = 0; m_rd = 0;
      vis_lvl = 0; vis_ack = 0; vis_rd = 0;
      exp_stream.delete(); exp_status.delete();
   endtask

   // one clock cycle: drive inputs at the falling edge, then apply the coming
   // rising edge to the model; vis_* describe what the DUT shows this cycle
   task automatic step(input bit rb, input bit c, input bit s, input bit w,
                       input logic [3:0] se, input logic [31:0] d, input bit r);
      bit acc, pop;
      @(negedge clk_i);
      rst_n_i = rb; wb_cyc_i = c; wb_stb_i = s; wb_we_i = w;
      wb_sel_i = se; wb_dat_i = d; out_ready_i = r;
      vis_ack = m_ack; vis_rd = m_rd; vis_lvl = lvl;
      if (!rb) begin
         model_reset();
         return;
      end
      acc   = c && s && !m_ack;
      pop   = r && (lvl > 0);
      m_ack = acc;
      m_rd  = acc && !w;
      if (acc && !w) begin
         exp_status.push_back({ovf, lvl == DEPTH, lvl == 0, 13'd0, lvl[15:0]});
         ovf = 0;
      end
      if (acc && w) begin
         if (lvl == DEPTH && !pop) ovf = 1;
         else begin
            exp_stream.push_back(masked(d, se));
            lvl++;
         end
      end
      if (pop) lvl--;
   endtask

   task automatic idle(input int n, input bit r);
      repeat (n) step(1, 0, 0, 0, 4'h0, 32'h0, r);
   endtask

   task automatic wb_write(input logic [31:0] d, input logic [3:0] se, input bit r1, input bit r2);
      step(1, 1, 1, 1, se, d, r1);
      step(1, 0, 0, 0, 4'h0, 32'h0, r2);
   endtask

   task automatic wb_read();
      step(1, 1, 1, 0, 4'h0, 32'h0, 0);
      step(1, 0, 0, 0, 4'h0, 32'h0, 0);
   endtask

   // monitor: sampled 1 time unit after the falling edge, well away from the rising edge
   always begin
      @(negedge clk_i);
      #1;
      check("ack", {31'd0, wb_ack_o}, {31'd0, vis_ack});
      check("stall", {31'd0, wb_stall_o}, {31'd0, !vis_ack && wb_cyc_i && wb_stb_i});
      check("err_rty", {30'd0, wb_err_o, wb_rty_o}, 32'd0);
      check("valid", {31'd0, out_valid_o}, {31'd0, vis_lvl > 0});
      if (vis_lvl > 0 && exp_stream.size() > 0) check("head", out_data_o, exp_stream[0]);
      else if (vis_lvl == 0) check("data_empty", out_data_o, 32'h0);
      if (vis_ack && vis_rd && exp_status.size() > 0) check("status", wb_dat_o, exp_status.pop_front());
      if (out_ready_i && vis_lvl > 0 && exp_stream.size() > 0) void'(exp_stream.pop_front());
   end

   initial begin
      model_reset();
      repeat (3) step(0, 0, 0, 0, 4'h0, 32'h0, 0);
      #1 check("rst_dat", wb_dat_o, 32'h0);

      // empty status, pops with nothing valid
      idle(2, 1);
      wb_read();
      #1 check("t5_empty", wb_dat_o, 32'h2000_0000);
      idle(3, 1);
      wb_read();
      #1 check("t5_empty2", wb_dat_o, 32'h2000_0000);

      // first write, fall-through head
      wb_write(32'hCAFE_F00D, 4'hF, 0, 0);
      #1 check("t1_valid", {31'd0, out_valid_o}, 32'd1);
      check("t1_data", out_data_o, 32'hCAFE_F00D);
      idle(1, 1); idle(1, 0);

      // byte lane masking
      wb_write(32'h1122_3344, 4'b0101, 0, 0);
      #1 check("t2_data", out_data_o, 32'h0022_0044);
      idle(1, 1); idle(1, 0);

      // overflow drop and sticky clear-on-read
      for (int i = 0; i < DEPTH; i++) wb_write(32'h100 + i, 4'hF, 0, 0);
      wb_write(32'hDEAD_BEEF, 4'hF, 0, 0);
      wb_read();
      #1 check("t3_ovf", wb_dat_o, 32'hC000_0010);
      wb_read();
      #1 check("t3_clr", wb_dat_o, 32'h4000_0010);
      idle(DEPTH + 2, 1); idle(1, 0);

      // full with simultaneous pop
      for (int i = 1; i <= DEPTH; i++) wb_write(i, 4'hF, 0, 0);
      wb_write(DEPTH + 1, 4'hF, 1, 0);
      wb_read();
      #1 check("t4_level", wb_dat_o, 32'h4000_0010);
      check("t4_head", out_data_o, 32'd2);
      idle(DEPTH + 2, 1); idle(1, 0);

      // strobe held high: accepts every other cycle
      step(1, 1, 1, 1, 4'hF, 32'hAAAA_0001, 0);
      step(1, 1, 1, 1, 4'hF, 32'hAAAA_0002, 0);
      step(1, 1, 1, 1, 4'hF, 32'hAAAA_0003, 0);
      step(1, 0, 0, 0, 4'h0, 32'h0, 0);
      wb_read();
      #1 check("b2b_level", wb_dat_o, 32'h0000_0002);
      idle(3, 1); idle(1, 0);

      // reset during the ack cycle
      step(1, 1, 1, 1, 4'hF, 32'h5555_AAAA, 0);
      @(posedge clk_i);
      #1 rst_n_i = 1'b0;
      model_reset();
      repeat (2) step(0, 0, 0, 0, 4'h0, 32'h0, 0);
      idle(1, 0);
      #1 check("t6_valid", {31'd0, out_valid_o}, 32'd0);
      wb_read();
      #1 check("t6_status", wb_dat_o, 32'h2000_0000);

      // randomized traffic
      for (int n = 0; n < 600; n++)
         step(($urandom % 200) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
              ($urandom % 3) != 0, 4'($urandom), $urandom, ($urandom % 3) == 0);
      idle(1, 0);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
